// File: rtl/axis_packet_fifo.sv
// Single-clock AXI4-Stream FIFO carrying {tlast,tstrb,tdata}, with optional store-and-forward
// framing, whole-packet drop on overflow/oversize, and registered occupancy status.
//   state    | meaning
//   ST_WRITE | beats are stored; tlast commits the packet
//   ST_DROP  | beats of the current packet are accepted and discarded until tlast
module axis_packet_fifo #(
  parameter int ADDR_WIDTH         = 10,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter bit FRAME_MODE         = 1'b0,
  parameter bit DROP_WHEN_FULL     = 1'b0,
  parameter int ALMOST_FULL_LEVEL  = (2 ** ADDR_WIDTH) - 16,
  parameter int ALMOST_EMPTY_LEVEL = 16
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic                            s00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  output logic [ADDR_WIDTH:0]             occupancy,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic                            good_frame,
  output logic                            drop_frame
);

  localparam int STRB_WIDTH  = C_AXIS_TDATA_WIDTH / 8;
  localparam int ENTRY_WIDTH = C_AXIS_TDATA_WIDTH + STRB_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {ST_WRITE, ST_DROP} wr_state_t;

  logic [ENTRY_WIDTH-1:0] mem [2 ** ADDR_WIDTH];
  logic [ENTRY_WIDTH-1:0] q_data;
  logic                   q_valid;

  wr_state_t         state, state_nxt;
  logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_nxt, wr_commit, wr_commit_nxt;
  logic [ADDR_WIDTH:0] rd_ptr, rd_addr, used_cnt;
  logic wr_en, good_nxt, drop_nxt;
  logic full, rd_empty, s_fire, out_load, rd_fetch;

  // rd_ptr releases a slot only when its beat leaves the output register, so the
  // two prefetched beats still count as occupied.
  assign used_cnt = wr_ptr - rd_ptr;
  assign full     = (used_cnt == DEPTH_CNT);
  assign rd_empty = FRAME_MODE ? (rd_addr == wr_commit) : (rd_addr == wr_ptr);
  assign s_fire   = s00_axis_tvalid & s00_axis_tready;
  assign out_load = ~m00_axis_tvalid | m00_axis_tready;
  assign rd_fetch = ~rd_empty & (~q_valid | out_load);

  always_comb begin
    if (axis_areset)
      s00_axis_tready = 1'b0;
    else if (FRAME_MODE && (DROP_WHEN_FULL || state == ST_DROP))
      s00_axis_tready = 1'b1;
    else
      s00_axis_tready = ~full;
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    wr_en         = 1'b0;
    good_nxt      = 1'b0;
    drop_nxt      = 1'b0;
    if (!FRAME_MODE) begin
      if (s_fire) begin
        wr_en      = 1'b1;
        wr_ptr_nxt = wr_ptr + PTR_ONE;
      end
      wr_commit_nxt = wr_ptr_nxt;
    end else begin
      case (state)
        ST_WRITE: begin
          if (s_fire && full) begin
            wr_ptr_nxt = wr_commit;
            if (s00_axis_tlast) drop_nxt  = 1'b1;
            else                state_nxt = ST_DROP;
          end else if (s_fire) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (s00_axis_tlast) begin
              wr_commit_nxt = wr_ptr + PTR_ONE;
              good_nxt      = 1'b1;
            end
          end else if (full && (wr_commit == rd_ptr)) begin
            // whole buffer is one unfinished packet: it can never complete
            wr_ptr_nxt = wr_commit;
            state_nxt  = ST_DROP;
          end
        end
        ST_DROP: begin
          wr_ptr_nxt = wr_commit;
          if (s_fire && s00_axis_tlast) begin
            drop_nxt  = 1'b1;
            state_nxt = ST_WRITE;
          end
        end
        default: state_nxt = ST_WRITE;
      endcase
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
    if (rd_fetch) q_data <= mem[rd_addr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state           <= ST_WRITE;
      wr_ptr          <= '0;
      wr_commit       <= '0;
      rd_ptr          <= '0;
      rd_addr         <= '0;
      q_valid         <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
      good_frame      <= 1'b0;
      drop_frame      <= 1'b0;
      occupancy       <= '0;
      almost_full     <= 1'b0;
      almost_empty    <= 1'b1;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      wr_commit  <= wr_commit_nxt;
      good_frame <= good_nxt;
      drop_frame <= drop_nxt;
      if (rd_fetch) rd_addr <= rd_addr + PTR_ONE;
      if (rd_fetch)      q_valid <= 1'b1;
      else if (out_load) q_valid <= 1'b0;
      if (out_load) begin
        m00_axis_tvalid <= q_valid;
        if (q_valid) {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} <= q_data;
      end
      if (m00_axis_tvalid && m00_axis_tready) rd_ptr <= rd_ptr + PTR_ONE;
      occupancy    <= used_cnt;
      almost_full  <= (used_cnt >= AF_CNT);
      almost_empty <= (used_cnt <= AE_CNT);
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench for axis_packet_fifo: three depth-16 instances (stream, frame+drop-when-full,
// frame only) driven by per-scenario tasks with hand-computed expectations.
module tb_axis_packet_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] s_tdata [3];
  logic [3:0]  s_tstrb [3];
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic        s_tlast [3];
  logic [31:0] m_tdata [3];
  logic [3:0]  m_tstrb [3];
  logic        m_tvalid [3];
  logic        m_tready [3];
  logic        m_tlast [3];
  logic [4:0]  occupancy [3];
  logic        almost_full [3];
  logic        almost_empty [3];
  logic        good_frame [3];
  logic        drop_frame [3];

  int checks = 0;
  int errors = 0;
  int gf_cnt [3];
  int df_cnt [3];
  logic [36:0] q0 [$];
  logic [36:0] q1 [$];
  logic [36:0] q2 [$];
  logic [36:0] hold [3];
  bit          hold_v [3];

  always #5 clk = ~clk;

  axis_packet_fifo #(.ADDR_WIDTH(4), .C_AXIS_TDATA_WIDTH(32), .FRAME_MODE(1'b0), .DROP_WHEN_FULL(1'b0),
                     .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)) u_stream (
    .axis_aclk(clk), .axis_areset(rst),
    .s00_axis_tdata(s_tdata[0]), .s00_axis_tstrb(s_tstrb[0]), .s00_axis_tvalid(s_tvalid[0]),
    .s00_axis_tready(s_tready[0]), .s00_axis_tlast(s_tlast[0]),
    .m00_axis_tdata(m_tdata[0]), .m00_axis_tstrb(m_tstrb[0]), .m00_axis_tvalid(m_tvalid[0]),
    .m00_axis_tready(m_tready[0]), .m00_axis_tlast(m_tlast[0]),
    .occupancy(occupancy[0]), .almost_full(almost_full[0]), .almost_empty(almost_empty[0]),
    .good_frame(good_frame[0]), .drop_frame(drop_frame[0]));

  axis_packet_fifo #(.ADDR_WIDTH(4), .C_AXIS_TDATA_WIDTH(32), .FRAME_MODE(1'b1), .DROP_WHEN_FULL(1'b1),
                     .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)) u_frame_dwf (
    .axis_aclk(clk), .axis_areset(rst),
    .s00_axis_tdata(s_tdata[1]), .s00_axis_tstrb(s_tstrb[1]), .s00_axis_tvalid(s_tvalid[1]),
    .s00_axis_tready(s_tready[1]), .s00_axis_tlast(s_tlast[1]),
    .m00_axis_tdata(m_tdata[1]), .m00_axis_tstrb(m_tstrb[1]), .m00_axis_tvalid(m_tvalid[1]),
    .m00_axis_tready(m_tready[1]), .m00_axis_tlast(m_tlast[1]),
    .occupancy(occupancy[1]), .almost_full(almost_full[1]), .almost_empty(almost_empty[1]),
    .good_frame(good_frame[1]), .drop_frame(drop_frame[1]));

  axis_packet_fifo #(.ADDR_WIDTH(4), .C_AXIS_TDATA_WIDTH(32), .FRAME_MODE(1'b1), .DROP_WHEN_FULL(1'b0),
                     .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)) u_frame (
    .axis_aclk(clk), .axis_areset(rst),
    .s00_axis_tdata(s_tdata[2]), .s00_axis_tstrb(s_tstrb[2]), .s00_axis_tvalid(s_tvalid[2]),
    .s00_axis_tready(s_tready[2]), .s00_axis_tlast(s_tlast[2]),
    .m00_axis_tdata(m_tdata[2]), .m00_axis_tstrb(m_tstrb[2]), .m00_axis_tvalid(m_tvalid[2]),
    .m00_axis_tready(m_tready[2]), .m00_axis_tlast(m_tlast[2]),
    .occupancy(occupancy[2]), .almost_full(almost_full[2]), .almost_empty(almost_empty[2]),
    .good_frame(good_frame[2]), .drop_frame(drop_frame[2]));

  // Output capture and hold-while-stalled watch, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        hold_v[i] = 1'b0;
      end else begin
        if (hold_v[i]) begin
          checks++;
          if (m_tvalid[i] !== 1'b1 || {m_tlast[i], m_tstrb[i], m_tdata[i]} !== hold[i]) begin
            errors++;
            $display("FAIL hold_stable dut%0d got valid=%b beat=%h want valid=1 beat=%h",
                     i, m_tvalid[i], {m_tlast[i], m_tstrb[i], m_tdata[i]}, hold[i]);
          end
        end
        hold_v[i] = m_tvalid[i] && !m_tready[i];
        hold[i]   = {m_tlast[i], m_tstrb[i], m_tdata[i]};
        if (m_tvalid[i] && m_tready[i]) begin
          case (i)
            0:       q0.push_back({m_tlast[i], m_tstrb[i], m_tdata[i]});
            1:       q1.push_back({m_tlast[i], m_tstrb[i], m_tdata[i]});
            default: q2.push_back({m_tlast[i], m_tstrb[i], m_tdata[i]});
          endcase
        end
        if (good_frame[i]) gf_cnt[i]++;
        if (drop_frame[i]) df_cnt[i]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns 1 ns after the edge that accepts it; tvalid is left high.
  task automatic send(input int d, input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    s_tdata[d] = data; s_tstrb[d] = strb; s_tlast[d] = last; s_tvalid[d] = 1'b1;
    while (!s_tready[d] && n < 100) begin step(1); n++; end
    if (!s_tready[d]) begin
      checks++; errors++;
      $display("FAIL send_timeout dut%0d data=%h tready=%b want 1", d, data, s_tready[d]);
    end else begin
      step(1);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (s_tready[d] !== 1'b0) begin errors++; $display("FAIL reset_tready_low dut%0d got %b want 0", d, s_tready[d]); end
    end
    step(2);
    rst = 1'b0;
    step(1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({m_tvalid[d], occupancy[d], almost_full[d], almost_empty[d], good_frame[d], drop_frame[d]} !== 10'b0_00000_0_1_0_0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got tvalid=%b occ=%0d af=%b ae=%b gf=%b df=%b want 0,0,0,1,0,0",
                 d, m_tvalid[d], occupancy[d], almost_full[d], almost_empty[d], good_frame[d], drop_frame[d]);
      end
      checks++;
      if (s_tready[d] !== 1'b1) begin errors++; $display("FAIL reset_tready_after dut%0d got %b want 1", d, s_tready[d]); end
    end
  endtask

  task automatic test_fill_drain();
    int n = 0;
    q0.delete();
    m_tready[0] = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 32'(i), 4'hF, (i == 15));
    s_tvalid[0] = 1'b0;
    checks++;
    if (s_tready[0] !== 1'b0) begin errors++; $display("FAIL fill_tready got %b want 0", s_tready[0]); end
    step(2);
    checks++;
    if (occupancy[0] !== 5'd16) begin errors++; $display("FAIL fill_occupancy got %0d want 16", occupancy[0]); end
    checks++;
    if (almost_full[0] !== 1'b1 || almost_empty[0] !== 1'b0) begin
      errors++; $display("FAIL fill_flags got af=%b ae=%b want af=1 ae=0", almost_full[0], almost_empty[0]);
    end
    m_tready[0] = 1'b1;
    while (q0.size() < 16 && n < 60) begin step(1); n++; end
    step(3);
    checks++;
    if (q0.size() !== 16) begin errors++; $display("FAIL drain_count got %0d want 16", q0.size()); end
    for (int i = 0; i < 16 && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {(i == 15), 4'hF, 32'(i)}) begin errors++; $display("FAIL drain_order beat %0d got %h want %h", i, q0[i], {(i == 15), 4'hF, 32'(i)}); end
    end
    checks++;
    if (occupancy[0] !== 5'd0 || almost_empty[0] !== 1'b1) begin
      errors++; $display("FAIL drain_occupancy got occ=%0d ae=%b want 0,1", occupancy[0], almost_empty[0]);
    end
  endtask

  task automatic test_latency_burst();
    int n = 0;
    int run = 0;
    m_tready[0] = 1'b1;
    s_tdata[0] = 32'hA5; s_tstrb[0] = 4'h1; s_tlast[0] = 1'b1; s_tvalid[0] = 1'b1;
    checks++;
    if (s_tready[0] !== 1'b1) begin errors++; $display("FAIL latency_tready got %b want 1", s_tready[0]); end
    step(1);
    s_tvalid[0] = 1'b0;
    step(1);
    checks++;
    if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL latency_n1 got tvalid=%b want 0", m_tvalid[0]); end
    step(1);
    checks++;
    if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 32'hA5) begin
      errors++; $display("FAIL latency_n2 got tvalid=%b tdata=%h want 1 a5", m_tvalid[0], m_tdata[0]);
    end
    step(3);
    q0.delete();
    fork
      begin
        for (int i = 0; i < 64; i++) send(0, 32'(100 + i), 4'hF, (i == 63));
        s_tvalid[0] = 1'b0;
      end
      begin
        while (!m_tvalid[0] && n < 20) begin step(1); n++; end
        while (m_tvalid[0] && run < 200) begin run++; step(1); end
      end
    join
    step(3);
    checks++;
    if (run !== 64) begin errors++; $display("FAIL burst_run got %0d consecutive cycles want 64", run); end
    checks++;
    if (q0.size() !== 64) begin errors++; $display("FAIL burst_count got %0d want 64", q0.size()); end
    for (int i = 0; i < 64 && i < q0.size(); i++) begin
      checks++;
      if (q0[i][31:0] !== 32'(100 + i)) begin errors++; $display("FAIL burst_order beat %0d got %h want %h", i, q0[i][31:0], 32'(100 + i)); end
    end
  endtask

  task automatic test_frame_release();
    int n = 0;
    q1.delete(); gf_cnt[1] = 0; df_cnt[1] = 0;
    m_tready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1, 32'(200 + i), 4'(i + 1), (i == 4));
      checks++;
      if (m_tvalid[1] !== 1'b0) begin errors++; $display("FAIL frame_early_valid beat %0d got %b want 0", i, m_tvalid[1]); end
    end
    s_tvalid[1] = 1'b0;
    step(1);
    checks++;
    if (m_tvalid[1] !== 1'b0) begin errors++; $display("FAIL frame_n1 got tvalid=%b want 0", m_tvalid[1]); end
    step(1);
    checks++;
    if (m_tvalid[1] !== 1'b1 || m_tdata[1] !== 32'd200) begin
      errors++; $display("FAIL frame_n2 got tvalid=%b tdata=%h want 1 c8", m_tvalid[1], m_tdata[1]);
    end
    while (q1.size() < 5 && n < 30) begin step(1); n++; end
    step(3);
    checks++;
    if (q1.size() !== 5) begin errors++; $display("FAIL frame_count got %0d want 5", q1.size()); end
    for (int i = 0; i < 5 && i < q1.size(); i++) begin
      checks++;
      if (q1[i] !== {(i == 4), 4'(i + 1), 32'(200 + i)}) begin
        errors++; $display("FAIL frame_beat %0d got %h want %h", i, q1[i], {(i == 4), 4'(i + 1), 32'(200 + i)});
      end
    end
    checks++;
    if (gf_cnt[1] !== 1 || df_cnt[1] !== 0) begin errors++; $display("FAIL frame_pulses got good=%0d drop=%0d want 1 0", gf_cnt[1], df_cnt[1]); end
  endtask

  task automatic test_drop_when_full();
    int n = 0;
    q1.delete();
    m_tready[1] = 1'b0;
    for (int i = 0; i < 14; i++) send(1, 32'(300 + i), 4'hF, (i == 6 || i == 13));
    s_tvalid[1] = 1'b0;
    step(2);
    checks++;
    if (occupancy[1] !== 5'd14) begin errors++; $display("FAIL dwf_pre_occupancy got %0d want 14", occupancy[1]); end
    gf_cnt[1] = 0; df_cnt[1] = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_tready[1] !== 1'b1) begin errors++; $display("FAIL dwf_accept beat %0d got tready=%b want 1", i, s_tready[1]); end
      send(1, 32'(400 + i), 4'hF, (i == 3));
    end
    s_tvalid[1] = 1'b0;
    checks++;
    if (drop_frame[1] !== 1'b1) begin errors++; $display("FAIL dwf_drop_pulse got %b want 1", drop_frame[1]); end
    step(1);
    checks++;
    if (drop_frame[1] !== 1'b0) begin errors++; $display("FAIL dwf_drop_pulse_end got %b want 0", drop_frame[1]); end
    step(1);
    checks++;
    if (occupancy[1] !== 5'd14) begin errors++; $display("FAIL dwf_post_occupancy got %0d want 14", occupancy[1]); end
    checks++;
    if (gf_cnt[1] !== 0 || df_cnt[1] !== 1) begin errors++; $display("FAIL dwf_pulses got good=%0d drop=%0d want 0 1", gf_cnt[1], df_cnt[1]); end
    m_tready[1] = 1'b1;
    while (q1.size() < 14 && n < 60) begin step(1); n++; end
    step(5);
    checks++;
    if (q1.size() !== 14) begin errors++; $display("FAIL dwf_out_count got %0d want 14", q1.size()); end
    for (int i = 0; i < 14 && i < q1.size(); i++) begin
      checks++;
      if (q1[i] !== {(i == 6 || i == 13), 4'hF, 32'(300 + i)}) begin
        errors++; $display("FAIL dwf_out beat %0d got %h want %h", i, q1[i], {(i == 6 || i == 13), 4'hF, 32'(300 + i)});
      end
    end
  endtask

  task automatic test_oversize_drop();
    int n = 0;
    q2.delete(); gf_cnt[2] = 0; df_cnt[2] = 0;
    m_tready[2] = 1'b1;
    for (int i = 0; i < 20; i++) send(2, 32'(500 + i), 4'hF, (i == 19));
    s_tvalid[2] = 1'b0;
    step(4);
    checks++;
    if (df_cnt[2] !== 1 || q2.size() !== 0) begin
      errors++; $display("FAIL oversize_drop got drop=%0d out=%0d want 1 0", df_cnt[2], q2.size());
    end
    for (int i = 0; i < 3; i++) send(2, 32'(600 + i), 4'(i + 8), (i == 2));
    s_tvalid[2] = 1'b0;
    while (q2.size() < 3 && n < 30) begin step(1); n++; end
    step(4);
    checks++;
    if (q2.size() !== 3) begin errors++; $display("FAIL oversize_next_count got %0d want 3", q2.size()); end
    for (int i = 0; i < 3 && i < q2.size(); i++) begin
      checks++;
      if (q2[i] !== {(i == 2), 4'(i + 8), 32'(600 + i)}) begin
        errors++; $display("FAIL oversize_next beat %0d got %h want %h", i, q2[i], {(i == 2), 4'(i + 8), 32'(600 + i)});
      end
    end
    checks++;
    if (gf_cnt[2] !== 1 || df_cnt[2] !== 1) begin errors++; $display("FAIL oversize_pulses got good=%0d drop=%0d want 1 1", gf_cnt[2], df_cnt[2]); end
  endtask

  task automatic test_random_reset();
    int n = 0;
    logic [36:0] exp;
    q0.delete();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          s_tvalid[0] = 1'b0;
          repeat ($urandom_range(0, 2)) step(1);
          send(0, 32'(1000 + i), 4'(i), (i % 8 == 7));
        end
        s_tvalid[0] = 1'b0;
      end
      begin
        while (q0.size() < 1000 && n < 20000) begin
          m_tready[0] = 1'($urandom_range(0, 1));
          step(1);
          n++;
        end
        m_tready[0] = 1'b0;
      end
    join
    checks++;
    if (q0.size() !== 1000) begin errors++; $display("FAIL random_count got %0d want 1000", q0.size()); end
    for (int i = 0; i < 1000 && i < q0.size(); i++) begin
      exp = {(i % 8 == 7), 4'(i), 32'(1000 + i)};
      checks++;
      if (q0[i] !== exp) begin errors++; $display("FAIL random_beat %0d got %h want %h", i, q0[i], exp); end
    end
    q0.delete();
    for (int i = 0; i < 3; i++) send(0, 32'(32'h6000 + i), 4'hF, 1'b0);
    s_tvalid[0] = 1'b0;
    step(2);
    checks++;
    if (m_tvalid[0] !== 1'b1 || occupancy[0] !== 5'd3) begin
      errors++; $display("FAIL prereset_state got tvalid=%b occ=%0d want 1 3", m_tvalid[0], occupancy[0]);
    end
    #3 rst = 1'b1;
    #2;
    checks++;
    if (m_tvalid[0] !== 1'b0 || occupancy[0] !== 5'd0 || s_tready[0] !== 1'b0) begin
      errors++; $display("FAIL async_reset got tvalid=%b occ=%0d tready=%b want 0 0 0", m_tvalid[0], occupancy[0], s_tready[0]);
    end
    step(2);
    rst = 1'b0;
    step(1);
    q0.delete();
    m_tready[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) send(0, 32'(32'h7000 + i), 4'(i + 3), (i == 3));
    s_tvalid[0] = 1'b0;
    while (q0.size() < 4 && n < 30) begin step(1); n++; end
    step(5);
    checks++;
    if (q0.size() !== 4) begin errors++; $display("FAIL postreset_count got %0d want 4", q0.size()); end
    for (int i = 0; i < 4 && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {(i == 3), 4'(i + 3), 32'(32'h7000 + i)}) begin
        errors++; $display("FAIL postreset_beat %0d got %h want %h", i, q0[i], {(i == 3), 4'(i + 3), 32'(32'h7000 + i)});
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      s_tdata[d] = '0; s_tstrb[d] = '0; s_tvalid[d] = 1'b0; s_tlast[d] = 1'b0;
      m_tready[d] = 1'b0; gf_cnt[d] = 0; df_cnt[d] = 0; hold_v[d] = 1'b0; hold[d] = '0;
    end
    test_reset();
    test_fill_drain();
    test_latency_burst();
    test_frame_release();
    test_drop_when_full();
    test_oversize_drop();
    test_random_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
